bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared WIDTH-bit bus with eight requesters.
- Wraps an internal 8:1 byte-select mux; the arbiter drives the 3-bit select, and the winning requester's data goes to a single consumer with a valid/ready handshake.
- Bounded bursts: each requester keeps the bus for at most MAX_BURST accepted beats while others wait.
- Sits between MPU units that write to a common destination (register-file write port, output bus) and that destination.

Parameters:
- WIDTH, 8: data width per requester and of the bus.
- MAX_BURST, 4: maximum accepted beats per grant. Legal range is 1 to 255; 1 gives per-beat round-robin.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request per requester; held high while the requester has data.
- din  in  8*WIDTH  requester data, flattened; requester i uses bits [i*WIDTH +: WIDTH].
- bus_ready  in  1  consumer can accept a beat this cycle.
- gnt  out  8  registered one-hot grant; all zero when idle.
- sel  out  3  registered index of the current owner; drives the internal mux.
- bus_data  out  WIDTH  din slice selected by sel (combinational).
- bus_valid  out  1  busy & req[sel] (combinational).
- busy  out  1  bus is owned (state BUSY).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, gnt = 0, sel = 0, busy = 0, burst_cnt = 0.
  - last = 7, so requester 0 has first priority.
  - bus_valid = 0, which follows combinationally from busy = 0.
- Round-robin pick:
  - Search req starting at index last+1, wrapping modulo 8.
  - The first set bit wins.
  - If only the previous owner is requesting, the search wraps back to it and it wins.
- IDLE:
  - bus_valid = 0; sel holds its previous value.
  - If req != 0 at an edge: go to BUSY, gnt = onehot(winner), sel = winner, burst_cnt = 0.
  - Request-to-grant latency is 1 cycle.
- BUSY:
  - bus_data = din[sel]; bus_valid = req[sel].
  - A beat is accepted when bus_valid & bus_ready. Each accepted beat increments burst_cnt.
- Release condition, evaluated at each BUSY edge:
  - (a) the owner's req[sel] is low, or
  - (b) a beat is accepted while burst_cnt == MAX_BURST-1.
- On release:
  - last = sel.
  - If any req bit is set at that edge, re-arbitrate in the same edge: new gnt/sel, burst_cnt = 0, stay in BUSY. There is no idle gap.
  - Otherwise go to IDLE with gnt = 0 and burst_cnt = 0.
- Stalls:
  - While bus_ready is low, burst_cnt holds and the grant is held indefinitely. There is no timeout.
  - The requester must hold din stable while bus_valid & !bus_ready.
- Owner drop: if the owner drops req while others wait, the bus moves on at the next edge. A dropped request has no pending beat, so nothing is lost.
- Simultaneous events: when a release and a new request land on the same edge, the new request takes part in that edge's arbitration.
- Reset mid-burst: all state clears immediately, asynchronously. bus_valid falls in the same cycle, and the in-flight beat is not counted.
- Width rule: burst_cnt width is clog2(MAX_BURST+1). burst_cnt never exceeds MAX_BURST-1.
- Invariants:
  - gnt always equals onehot(sel) when busy = 1, and is zero otherwise.
  - At most one bit of gnt is set.

Test Plan:
1. Reset, then req = 8'b0000_0001, din0 = 8'hAA, bus_ready = 1.
   - Next cycle: gnt = 01, sel = 0, bus_valid = 1, bus_data = AA.
   - 4 beats accepted, then release.
   - With no other requester, requester 0 is re-granted immediately and burst_cnt restarts at 0.
2. req = 8'b1000_0101 held, bus_ready = 1, MAX_BURST = 4.
   - Grants rotate 0 → 2 → 7 → 0.
   - Each owner holds exactly 4 cycles, with no idle cycle between owners.
3. Owner 2 granted; bus_ready = 0 for 5 cycles, then 1.
   - gnt stays 04 and burst_cnt stays 0 during the stall.
   - Afterwards, 4 beats complete before rotation.
4. Owner 3 drops req after 2 beats while req5 = 1.
   - Next edge: gnt = 20, sel = 5, burst_cnt = 0.
   - With no other requests pending, the block goes to IDLE and gnt = 0.
5. Assert rst mid-burst with sel = 6, then release rst, req = 8'hFF.
   - bus_valid and gnt clear at once.
   - After reset, the first grant goes to requester 0 (last reset to 7).
6. MAX_BURST = 1, req = 8'hFF, bus_ready = 1.
   - sel walks 0, 1, …, 7, 0, one per cycle.
   - bus_data matches the din pattern AA, 55, CC, 33, E0, 0F, 00, FF.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for eight requesters sharing one WIDTH-bit bus,
// with bounded bursts and a valid/ready handshake toward a single consumer.
module bus_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           req,
    input  logic [8*WIDTH-1:0]   din,
    input  logic                 bus_ready,
    output logic [7:0]           gnt,
    output logic [2:0]           sel,
    output logic [WIDTH-1:0]     bus_data,
    output logic                 bus_valid,
    output logic                 busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t          r_state;
    logic [7:0]      r_gnt;
    logic [2:0]      r_sel;
    logic [2:0]      r_last;
    logic [CW-1:0]   r_burst_cnt;

    logic [2:0]      w_base;
    logic [2:0]      w_win;
    logic            w_accept;
    logic            w_release;

    // First set request after base, wrapping; base itself is checked last.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        win   = base;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = base + 3'(k);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // On a release the outgoing owner becomes the new priority base.
    assign w_base    = (r_state == BUSY) ? r_sel : r_last;
    assign w_win     = rr_pick(req, w_base);
    assign w_accept  = bus_valid & bus_ready;
    assign w_release = !req[r_sel] | (w_accept & (r_burst_cnt == LAST_BEAT));

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = (r_state == BUSY);
    assign bus_valid = busy & req[r_sel];
    assign bus_data  = din[r_sel*WIDTH +: WIDTH];

    // Ownership FSM: grant, burst counting and release/re-arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= 8'h00;
            r_sel       <= 3'd0;
            r_last      <= 3'd7;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req != 8'h00) begin
                        r_state     <= BUSY;
                        r_gnt       <= 8'h01 << w_win;
                        r_sel       <= w_win;
                        r_burst_cnt <= '0;
                    end else begin
                        r_gnt <= 8'h00;
                    end
                end
                BUSY: begin
                    if (w_release) begin
                        r_last      <= r_sel;
                        r_burst_cnt <= '0;
                        if (req != 8'h00) begin
                            r_gnt <= 8'h01 << w_win;
                            r_sel <= w_win;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= 8'h00;
                        end
                    end else if (w_accept) begin
                        r_burst_cnt <= r_burst_cnt + CW'(1);
                    end else begin
                        r_burst_cnt <= r_burst_cnt;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt       <= 8'h00;
                    r_burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: MAX_BURST=4 instance for most scenarios,
// a MAX_BURST=1 instance for per-beat round-robin.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req = 8'h00;
    logic [63:0] din = 64'h0;
    logic        bus_ready = 1'b0;

    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic [7:0]  bus_data;
    logic        bus_valid;
    logic        busy;

    logic [7:0]  gnt1;
    logic [2:0]  sel1;
    logic [7:0]  bus_data1;
    logic        bus_valid1;
    logic        busy1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] pat [8];

    always #5 clk = ~clk;

    bus_arbiter #(.WIDTH(8), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .bus_ready(bus_ready),
        .gnt(gnt), .sel(sel), .bus_data(bus_data), .bus_valid(bus_valid), .busy(busy)
    );

    bus_arbiter #(.WIDTH(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .din(din), .bus_ready(bus_ready),
        .gnt(gnt1), .sel(sel1), .bus_data(bus_data1), .bus_valid(bus_valid1), .busy(busy1)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 8'h00; bus_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 8; i++) din[i*8 +: 8] = pat[i];
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || bus_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: gnt=%h sel=%0d busy=%b valid=%b, want 00/0/0/0", gnt, sel, busy, bus_valid);
        end
        n_vec++;
        if (u_dut.r_last !== 3'd7 || u_dut.r_burst_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: last=%0d cnt=%0d, want 7/0", u_dut.r_last, u_dut.r_burst_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_requester();
        do_reset();
        din[7:0] = 8'hAA; req = 8'h01; bus_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (gnt !== 8'h01 || sel !== 3'd0 || bus_valid !== 1'b1 || bus_data !== 8'hAA) begin
                n_err++;
                $display("FAIL single_grant[%0d]: gnt=%h sel=%0d valid=%b data=%h, want 01/0/1/AA", i, gnt, sel, bus_valid, bus_data);
            end
            n_vec++;
            if (u_dut.r_burst_cnt !== 3'(i % 4)) begin
                n_err++;
                $display("FAIL single_cnt[%0d]: cnt=%0d, want %0d", i, u_dut.r_burst_cnt, i % 4);
            end
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp_gnt;
        logic [2:0] exp_sel;
        do_reset();
        load_pattern();
        req = 8'b1000_0101; bus_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (i / 4)
                0:       begin exp_gnt = 8'h01; exp_sel = 3'd0; end
                1:       begin exp_gnt = 8'h04; exp_sel = 3'd2; end
                2:       begin exp_gnt = 8'h80; exp_sel = 3'd7; end
                default: begin exp_gnt = 8'h01; exp_sel = 3'd0; end
            endcase
            n_vec++;
            if (gnt !== exp_gnt || sel !== exp_sel || bus_valid !== 1'b1 || bus_data !== pat[exp_sel]) begin
                n_err++;
                $display("FAIL rotation[%0d]: gnt=%h sel=%0d valid=%b data=%h, want %h/%0d/1/%h",
                         i, gnt, sel, bus_valid, bus_data, exp_gnt, exp_sel, pat[exp_sel]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        load_pattern();
        req = 8'h04; bus_ready = 1'b0;
        @(negedge clk);
        req = 8'h05;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (gnt !== 8'h04 || u_dut.r_burst_cnt !== 3'd0 || bus_valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: gnt=%h cnt=%0d valid=%b, want 04/0/1", i, gnt, u_dut.r_burst_cnt, bus_valid);
            end
        end
        bus_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (gnt !== 8'h04 || u_dut.r_burst_cnt !== 3'(i)) begin
                n_err++;
                $display("FAIL stall_resume[%0d]: gnt=%h cnt=%0d, want 04/%0d", i, gnt, u_dut.r_burst_cnt, i);
            end
        end
        @(negedge clk);
        n_vec++;
        if (gnt !== 8'h01 || sel !== 3'd0 || u_dut.r_burst_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL stall_rotate: gnt=%h sel=%0d cnt=%0d, want 01/0/0", gnt, sel, u_dut.r_burst_cnt);
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        load_pattern();
        req = 8'h08; bus_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (gnt !== 8'h08 || sel !== 3'd3) begin
            n_err++;
            $display("FAIL drop_grant3: gnt=%h sel=%0d, want 08/3", gnt, sel);
        end
        req = 8'h28;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (gnt !== 8'h08 || u_dut.r_burst_cnt !== 3'd2) begin
            n_err++;
            $display("FAIL drop_two_beats: gnt=%h cnt=%0d, want 08/2", gnt, u_dut.r_burst_cnt);
        end
        req = 8'h20;
        @(negedge clk);
        n_vec++;
        if (gnt !== 8'h20 || sel !== 3'd5 || u_dut.r_burst_cnt !== 3'd0 || bus_data !== pat[5]) begin
            n_err++;
            $display("FAIL drop_move5: gnt=%h sel=%0d cnt=%0d data=%h, want 20/5/0/%h", gnt, sel, u_dut.r_burst_cnt, bus_data, pat[5]);
        end
        req = 8'h00;
        @(negedge clk);
        n_vec++;
        if (gnt !== 8'h00 || busy !== 1'b0 || bus_valid !== 1'b0 || sel !== 3'd5) begin
            n_err++;
            $display("FAIL drop_idle: gnt=%h busy=%b valid=%b sel=%0d, want 00/0/0/5", gnt, busy, bus_valid, sel);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load_pattern();
        req = 8'h40; bus_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sel !== 3'd6 || bus_valid !== 1'b1 || gnt !== 8'h40) begin
            n_err++;
            $display("FAIL midrst_owner6: sel=%0d valid=%b gnt=%h, want 6/1/40", sel, bus_valid, gnt);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus_valid !== 1'b0 || gnt !== 8'h00 || busy !== 1'b0 || u_dut.r_burst_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL midrst_clear: valid=%b gnt=%h busy=%b cnt=%0d, want 0/00/0/0", bus_valid, gnt, busy, u_dut.r_burst_cnt);
        end
        req = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (gnt !== 8'h01 || sel !== 3'd0 || bus_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_first: gnt=%h sel=%0d valid=%b, want 01/0/1", gnt, sel, bus_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_sel;
        do_reset();
        load_pattern();
        req = 8'hFF; bus_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            exp_sel = 3'(i % 8);
            n_vec++;
            if (sel1 !== exp_sel || gnt1 !== (8'h01 << exp_sel) || bus_data1 !== pat[exp_sel] ||
                bus_valid1 !== 1'b1 || busy1 !== 1'b1) begin
                n_err++;
                $display("FAIL per_beat[%0d]: sel=%0d gnt=%h data=%h valid=%b busy=%b, want %0d/%h/%h/1/1",
                         i, sel1, gnt1, bus_data1, bus_valid1, busy1, exp_sel, 8'h01 << exp_sel, pat[exp_sel]);
            end
        end
    endtask

    initial begin
        pat[0] = 8'hAA; pat[1] = 8'h55; pat[2] = 8'hCC; pat[3] = 8'h33;
        pat[4] = 8'hE0; pat[5] = 8'h0F; pat[6] = 8'h00; pat[7] = 8'hFF;
        test_reset();
        test_single_requester();
        test_rotation();
        test_stall();
        test_owner_drop();
        test_reset_mid_burst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
